// File: rtl/chi_slice_stage.sv
// Slice-serial Keccak chi stage: captures one 25-bit slice, rewrites it one row per
// cycle into a separate result register, then hands it downstream.
module chi_slice_stage #(
  parameter int SLICES = 64,
  parameter int SW     = $clog2(SLICES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [24:0]   in_slice,
  output logic          in_ready,
  output logic          out_valid,
  output logic [24:0]   out_slice,
  input  logic          out_ready,
  output logic [SW-1:0] slice_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ROW  = 3'd2,
    EMIT = 3'd3,
    FIN  = 3'd4
  } state_e;

  localparam logic [SW-1:0] LAST_IDX = SW'(SLICES - 1);

  state_e        stateR;
  state_e        nextStateS;
  logic [24:0]   workR;
  logic [24:0]   outSliceR;
  logic [2:0]    rowCntR;
  logic [SW-1:0] sliceIdxR;
  logic          inReadyR;
  logic          outValidR;
  logic          busyR;
  logic          doneR;

  // Row chi: bit x = a[x] ^ (~a[x+1] & a[x+2]), indices mod 5.
  function automatic logic [4:0] chiRow(input logic [4:0] r);
    chiRow = r ^ (~{r[0], r[4:1]} & {r[1:0], r[4:2]});
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Next-state decode.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (start) nextStateS = LOAD;
        else       nextStateS = IDLE;
      end
      LOAD: begin
        if (in_valid) nextStateS = ROW;
        else          nextStateS = LOAD;
      end
      ROW: begin
        if (rowCntR == 3'd4) nextStateS = EMIT;
        else                 nextStateS = ROW;
      end
      EMIT: begin
        if (!out_ready)               nextStateS = EMIT;
        else if (sliceIdxR == LAST_IDX) nextStateS = FIN;
        else                          nextStateS = LOAD;
      end
      FIN:     nextStateS = IDLE;
      default: nextStateS = IDLE;
    endcase
  end

  // Datapath: slice capture, row-by-row result build, slice index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      workR     <= 25'd0;
      outSliceR <= 25'd0;
      rowCntR   <= 3'd0;
      sliceIdxR <= {SW{1'b0}};
    end else begin
      case (stateR)
        IDLE: begin
          if (start) sliceIdxR <= {SW{1'b0}};
        end
        LOAD: begin
          if (in_valid) begin
            workR   <= in_slice;
            rowCntR <= 3'd0;
          end
        end
        ROW: begin
          case (rowCntR)
            3'd0:    outSliceR[4:0]   <= chiRow(workR[4:0]);
            3'd1:    outSliceR[9:5]   <= chiRow(workR[9:5]);
            3'd2:    outSliceR[14:10] <= chiRow(workR[14:10]);
            3'd3:    outSliceR[19:15] <= chiRow(workR[19:15]);
            3'd4:    outSliceR[24:20] <= chiRow(workR[24:20]);
            default: outSliceR        <= outSliceR;
          endcase
          // Counter stays inside 0..4.
          if (rowCntR == 3'd4) rowCntR <= 3'd0;
          else                 rowCntR <= rowCntR + 3'd1;
        end
        EMIT: begin
          if (out_ready && (sliceIdxR != LAST_IDX)) sliceIdxR <= sliceIdxR + {{(SW-1){1'b0}}, 1'b1};
        end
        FIN:     sliceIdxR <= {SW{1'b0}};
        default: sliceIdxR <= sliceIdxR;
      endcase
    end
  end

  // Registered status outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inReadyR  <= 1'b0;
      outValidR <= 1'b0;
      busyR     <= 1'b0;
      doneR     <= 1'b0;
    end else begin
      inReadyR  <= (nextStateS == LOAD);
      outValidR <= (nextStateS == EMIT);
      busyR     <= (nextStateS != IDLE);
      doneR     <= (nextStateS == FIN);
    end
  end

  assign in_ready  = inReadyR;
  assign out_valid = outValidR;
  assign out_slice = outSliceR;
  assign slice_idx = sliceIdxR;
  assign busy      = busyR;
  assign done      = doneR;

endmodule

// File: doc/chi_slice_stage.md
# chi_slice_stage

Slice-serial chi-step engine for the Keccak round datapath. It sits directly downstream of the permutation (pi) stage. It accepts one 25-bit state slice at a time over a valid/ready handshake and applies the chi non-linearity one row per cycle. It returns the transformed slice over a second valid/ready handshake, and flags completion after a full state of SLICES slices.

## Interface
- SLICES, 64: slices per state (lane length); must be >= 2.
- SW, $clog2(SLICES): width of slice counter.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low (asserted at 0).
- start  input  1  begin a new state pass; sampled only in IDLE.
- in_valid  input  1  upstream slice available.
- in_slice  input  25  slice from pi stage; bit index 5*y+x, so row y occupies [5y+4:5y].
- in_ready  output  1  stage can accept a slice.
- out_valid  output  1  out_slice holds a finished slice.
- out_slice  output  25  chi result, same indexing as in_slice.
- out_ready  input  1  downstream accepts out_slice.
- slice_idx  output  SW  index k of slice currently held or processed.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last slice is consumed downstream.

## Operation
- States: IDLE, LOAD, ROW, EMIT, FIN.
- IDLE:
  - start=1 -> LOAD, slice_idx<=0.
  - start=0 -> stay.
- LOAD:
  - in_ready=1.
  - in_valid&in_ready captures in_slice into the working register.
  - row counter<=0, -> ROW.
- ROW: for row y = counter and each x in 0..4, compute out_slice[5y+x] <= A[x,y] ^ (~A[(x+1) mod 5,y] & A[(x+2) mod 5,y]).
  - Uses the captured slice only; there is no in-place hazard because the result register is separate from the working register.
  - Counter 0..4; after y=4 -> EMIT.
- EMIT:
  - out_valid=1; out_slice stable.
  - Stay while out_ready=0.
  - On out_ready:
    - slice_idx==SLICES-1 -> FIN.
    - Otherwise slice_idx+1 -> LOAD.
- FIN: done=1 for exactly one cycle, slice_idx<=0, -> IDLE.
- start outside IDLE is ignored.
- in_valid outside LOAD is ignored; in_ready=0 there.
- Row index arithmetic is mod 5 with 3-bit counters; the counter never takes values 5..7.
- slice_idx wraps to 0 only through FIN, never by overflow.

## Timing
- Reset values:
  - state IDLE.
  - in_ready, out_valid, busy, done = 0.
  - out_slice = 0, slice_idx = 0.
  - Working register = 0, row counter = 0.
- Reset mid-operation aborts immediately.
  - No done pulse is produced.
  - A partial out_slice is discarded; out_slice returns to 0.
- Input handshake in cycle t:
  - ROW y=0..4 in cycles t+1..t+5.
  - out_valid first high in cycle t+6.
- Minimum 7 cycles per slice (LOAD+5 ROW+EMIT) with in_valid and out_ready held high.
  - Full state takes 7*SLICES+1 cycles from the first LOAD to done, plus 1 cycle from start in IDLE.
- out_ready is sampled only while out_valid=1.
  - out_valid drops the cycle after the handshake.
- done rises the cycle after the final EMIT handshake.
- A new start is accepted in the cycle after done, with the state back in IDLE.

## Test plan
- Zero slice: start, in_slice=25'h0000000 -> out_slice=25'h0000000 at t+6, slice_idx=0.
- Single bit A[0,0]: in_slice=25'h0000001 -> out_slice=25'h0000009.
- All ones: in_slice=25'h1FFFFFF -> out_slice=25'h1FFFFFF.
- Row-2 pattern: in_slice=25'h0000800 (A[1,2]=1) -> out_slice=25'h0004800.
- Backpressure and streaming, SLICES=4:
  - With out_ready=0 for 10 cycles in EMIT: out_valid stays 1, out_slice unchanged, in_ready=0.
  - Stream 4 slices with random values; results match the reference chi.
  - done pulses exactly once, 1 cycle after the 4th output handshake.
  - Total 29 cycles from the first LOAD with no stalls.
- Reset mid-ROW, asserting rst=0 at row 2:
  - All outputs return to reset values asynchronously; no done.
  - A following start processes the next slice with slice_idx=0.
